// File: rtl/imem_boot_loader.sv
// Boot loader + instruction RAM: receives a length-prefixed byte stream, fills word RAM,
// then releases the CPU from reset. Optional trailing checksum byte when BOOT_CHECKSUM_EN is defined.
module imem_boot_loader #(
  parameter  int DEPTH_WORDS = 64,
  localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  input  logic [31:0] PC,
  output logic [31:0] Instr,
  output logic        cpu_rst,
  output logic        load_done,
  output logic        load_err
);

  localparam logic [2:0] S_LEN0 = 3'd0;
  localparam logic [2:0] S_LEN1 = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;
`ifdef BOOT_CHECKSUM_EN
  localparam logic [2:0] S_CSUM = 3'd5;
`endif
  localparam logic [16:0] DEPTH_L = 17'(DEPTH_WORDS);

  logic [2:0]     state, state_nxt;
  logic [15:0]    n_words;
  logic [IDX_W:0] word_cnt;
  logic [1:0]     bcnt;
  logic [23:0]    hold;
  logic [31:0]    mem [DEPTH_WORDS];

  logic        accept, we, last_word;
  logic [15:0] len_full;

  assign accept    = byte_valid & byte_ready;
  assign len_full  = {byte_data, n_words[7:0]};
  assign last_word = (17'(word_cnt) + 17'd1) == {1'b0, n_words};
  assign we        = accept && !rst && (state == S_DATA) && (bcnt == 2'd3);

`ifdef BOOT_CHECKSUM_EN
  logic [7:0] csum;
  always_ff @(posedge clk) begin
    if (rst)                           csum <= '0;
    else if (accept && state == S_DATA) csum <= csum + byte_data;
  end
`endif

  always_comb begin
    state_nxt = state;
    if (accept) begin
      case (state)
        S_LEN0: state_nxt = S_LEN1;
        S_LEN1: state_nxt = (len_full == '0 || {1'b0, len_full} > DEPTH_L) ? S_ERR : S_DATA;
        S_DATA: if (bcnt == 2'd3 && last_word)
`ifdef BOOT_CHECKSUM_EN
                  state_nxt = S_CSUM;
        S_CSUM: state_nxt = (byte_data == csum) ? S_RUN : S_ERR;
`else
                  state_nxt = S_RUN;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_LEN0;
      n_words    <= '0;
      word_cnt   <= '0;
      bcnt       <= '0;
      hold       <= '0;
      byte_ready <= 1'b1;
      cpu_rst    <= 1'b1;
    end else begin
      state      <= state_nxt;
      // Outputs are registered off the next state so they line up with it.
      byte_ready <= (state_nxt != S_RUN) && (state_nxt != S_ERR);
      cpu_rst    <= (state_nxt != S_RUN);
      if (accept) begin
        case (state)
          S_LEN0: n_words[7:0]  <= byte_data;
          S_LEN1: n_words[15:8] <= byte_data;
          S_DATA: begin
            bcnt <= bcnt + 2'd1;
            if (bcnt != 2'd3) hold[8*bcnt +: 8] <= byte_data;
            else              word_cnt <= word_cnt + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // RAM is deliberately not reset; word_cnt alone decides what is readable.
  always_ff @(posedge clk) begin
    if (we) mem[word_cnt[IDX_W-1:0]] <= {byte_data, hold};
  end

  logic in_range;
  assign in_range  = (PC[31:IDX_W+2] == '0) && ({1'b0, PC[IDX_W+1:2]} < word_cnt);
  assign Instr     = in_range ? mem[PC[IDX_W+1:2]] : 32'h0000_0000;
  assign load_done = (state == S_RUN);
  assign load_err  = (state == S_ERR);

  logic unused_pc;
  assign unused_pc = &{1'b0, PC[1:0]};

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed + randomized bench for imem_boot_loader against a word-array reference model.
module tb_imem_boot_loader;
  localparam int DEPTH = 64;

  logic        clk = 0, rst = 1, byte_valid = 0;
  logic [7:0]  byte_data = 0;
  logic [31:0] pc = 0;
  logic        byte_ready, cpu_rst, load_done, load_err;
  logic [31:0] Instr;

  imem_boot_loader #(.DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .PC(pc), .Instr(Instr), .cpu_rst(cpu_rst),
    .load_done(load_done), .load_err(load_err));

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;
  logic [31:0] model[$];
  int loaded = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] exp_instr(input logic [31:0] a);
    int idx;
    if (a >= 32'(DEPTH * 4)) return 32'h0;
    idx = int'(a / 4);
    if (idx >= loaded) return 32'h0;
    return model[idx];
  endfunction

  task automatic read_check(input string tag, input logic [31:0] a);
    pc = a;
    #1;
    check(tag, Instr, exp_instr(a));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; byte_valid = 0;
    @(negedge clk);
    rst = 0;
    loaded = 0;
    model.delete();
  endtask

  task automatic send(input logic [7:0] b, input bit toggle);
    @(negedge clk);
    if (toggle) begin
      byte_valid = 0;
      @(negedge clk);
    end
    byte_valid = 1; byte_data = b;
    check("byte_ready_during_load", byte_ready, 1);
    @(posedge clk);
  endtask

  task automatic check_status(input string tag, input bit done, input bit err);
    check({tag, "_done"}, load_done, done);
    check({tag, "_err"}, load_err, err);
    check({tag, "_cpu_rst"}, cpu_rst, !done);
    check({tag, "_ready"}, byte_ready, !(done || err));
  endtask

  task automatic load(input logic [31:0] w[$], input bit toggle, input bit bad_csum);
    int n;
    logic [15:0] len;
    logic [7:0] b, sum;
    bit good;
    n = w.size(); len = 16'(n); sum = 0;
    send(len[7:0], toggle);
    send(len[15:8], toggle);
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 4; k++) begin
        b = w[i][8*k +: 8];
        sum = sum + b;
        send(b, toggle);
      end
`ifdef BOOT_CHECKSUM_EN
    send(bad_csum ? sum + 8'd1 : sum, toggle);
    good = !bad_csum;
`else
    good = 1;
`endif
    @(negedge clk);
    byte_valid = 0;
    model = w; loaded = n;
    check_status("load", good, !good);
  endtask

  task automatic hold_valid(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      byte_valid = 1; byte_data = 8'($urandom);
    end
    @(negedge clk);
    byte_valid = 0;
  endtask

  initial begin
    logic [31:0] w[$];
    logic [31:0] a;
    int n;

    // reset state
    do_reset();
    check_status("reset", 0, 0);
    read_check("reset_instr0", 0);

    // basic N=2 load, valid held high
    w = '{32'hE280_0005, 32'hE281_1003};
    load(w, 0, 0);
    pc = 0; #1; check("n2_pc0", Instr, 32'hE280_0005);
    pc = 4; #1; check("n2_pc4", Instr, 32'hE281_1003);
    pc = 8; #1; check("n2_pc8", Instr, 32'h0);
    hold_valid(5);
    check_status("run_ignore", 1, 0);
    read_check("run_ignore_pc4", 4);

    // same stream with gapped valid
    do_reset();
    load(w, 1, 0);
    read_check("gap_pc0", 0);
    read_check("gap_pc4", 4);
    read_check("gap_pc8", 8);

    // zero length
    do_reset();
    send(8'h00, 0); send(8'h00, 0);
    @(negedge clk); byte_valid = 0;
    check_status("len0", 0, 1);
    hold_valid(4);
    check_status("len0_hold", 0, 1);

    // length too large
    do_reset();
    send(8'h41, 0); send(8'h00, 0);
    @(negedge clk); byte_valid = 0;
    check_status("len65", 0, 1);

    // abort mid-load then reload
    do_reset();
    send(8'h02, 0); send(8'h00, 0);
    for (int i = 0; i < 5; i++) send(8'(i + 8'h11), 0);
    do_reset();
    check_status("abort", 0, 0);
    read_check("abort_pc0", 0);
    w = '{32'hDEAD_BEEF};
    load(w, 0, 0);
    pc = 0; #1; check("reload_pc0", Instr, 32'hDEAD_BEEF);
    pc = 4; #1; check("reload_pc4", Instr, 32'h0);

    // full depth
    do_reset();
    w.delete();
    for (int i = 0; i < DEPTH; i++) w.push_back(32'h1000_0000 + 32'(i));
    load(w, 0, 0);
    pc = 252; #1; check("full_pc252", Instr, 32'h1000_003F);
    read_check("full_pc253", 253);
    pc = 256; #1; check("full_pc256", Instr, 32'h0);
    pc = 32'h1000_0000; #1; check("full_pc_high", Instr, 32'h0);
    read_check("full_pc0", 0);

    // randomized loads
    for (int r = 0; r < 3; r++) begin
      do_reset();
      n = int'($urandom_range(1, DEPTH));
      w.delete();
      for (int i = 0; i < n; i++) w.push_back($urandom);
      load(w, bit'($urandom_range(0, 1)), 0);
      for (int j = 0; j < 20; j++) begin
        a = 32'($urandom_range(0, 300));
        if (j % 5 == 4) a = a | (32'h1 << $urandom_range(8, 31));
        read_check("rand_instr", a);
      end
    end

`ifdef BOOT_CHECKSUM_EN
    do_reset();
    w = '{32'h0403_0201};
    load(w, 0, 0);
    read_check("csum_ok_pc0", 0);
    do_reset();
    load(w, 0, 1);
    check("csum_bad_cpu_rst", cpu_rst, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
